// File: rtl/temporal_ngram_encoder.sv
// Temporal N-gram encoder: majority-fuses three modality hypervectors, binds with rotated history.
// Optional macro NGRAM_COUNT_EN adds a 16-bit output-transfer counter port NgramCnt_DO.
module temporal_ngram_encoder #(
   parameter int unsigned HV_DIMENSION = 2000,
   parameter int unsigned NGRAM_SIZE   = 3,
   parameter int unsigned CNT_WIDTH    = 3
) (
   input  logic                      Clk_CI,
   input  logic                      Reset_RBI,
   input  logic                      ValidIn_SI,
   output logic                      ReadyOut_SO,
   input  logic [0:HV_DIMENSION-1]   HypervectorIn_mod1_DI,
   input  logic [0:HV_DIMENSION-1]   HypervectorIn_mod2_DI,
   input  logic [0:HV_DIMENSION-1]   HypervectorIn_mod3_DI,
   input  logic                      ClearHistory_SI,
   output logic                      ValidOut_SO,
   input  logic                      ReadyIn_SI,
   output logic [0:HV_DIMENSION-1]   HypervectorOut_DO
`ifdef NGRAM_COUNT_EN
   ,
   output logic [15:0]               NgramCnt_DO
`endif
);

   typedef logic [0:HV_DIMENSION-1] hv_t;
   typedef enum logic {FILL, STREAM} state_t;

   localparam logic [CNT_WIDTH-1:0] NGRAM_C = CNT_WIDTH'(NGRAM_SIZE);

   hv_t                  fused, bound, ngram;
   logic                 accept, xfer, emit, window_full;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] fill_q, fill_d, fill_base, fill_inc;

   assign fused = (HypervectorIn_mod1_DI & HypervectorIn_mod2_DI) |
                  (HypervectorIn_mod1_DI & HypervectorIn_mod3_DI) |
                  (HypervectorIn_mod2_DI & HypervectorIn_mod3_DI);
   assign ngram = fused ^ bound;

   assign ReadyOut_SO = !ValidOut_SO || ReadyIn_SI;
   assign accept      = ValidIn_SI && ReadyOut_SO;
   assign xfer        = ValidOut_SO && ReadyIn_SI;

   // In STREAM the counter sits at NGRAM_SIZE and +1 may wrap, so rely on the state there.
   assign fill_base   = ClearHistory_SI ? '0 : fill_q;
   assign fill_inc    = fill_base + 1'b1;
   assign window_full = (state_q == STREAM && !ClearHistory_SI) || (fill_inc >= NGRAM_C);
   assign emit        = accept && window_full;

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      if (ClearHistory_SI) begin
         state_d = FILL;
         fill_d  = '0;
      end
      if (accept) begin
         if (window_full) begin
            state_d = STREAM;
            fill_d  = NGRAM_C;
         end else begin
            fill_d  = fill_inc;
         end
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (!Reset_RBI) begin
         state_q           <= FILL;
         fill_q            <= '0;
         ValidOut_SO       <= 1'b0;
         HypervectorOut_DO <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         if (emit) begin
            ValidOut_SO       <= 1'b1;
            HypervectorOut_DO <= ngram;
         end else if (xfer) begin
            ValidOut_SO       <= 1'b0;
         end
      end
   end

   generate
      if (NGRAM_SIZE > 1) begin : g_hist
         // hist_q[j] is H(j+1); it is rotated j+1 positions before binding.
         hv_t hist_q [NGRAM_SIZE-1];
         hv_t rot;

         always_ff @(posedge Clk_CI) begin
            if (!Reset_RBI) begin
               for (int j = 0; j < NGRAM_SIZE-1; j++) hist_q[j] <= '0;
            end else begin
               if (ClearHistory_SI)
                  for (int j = 0; j < NGRAM_SIZE-1; j++) hist_q[j] <= '0;
               if (accept) begin
                  hist_q[0] <= fused;
                  for (int j = 1; j < NGRAM_SIZE-1; j++)
                     hist_q[j] <= ClearHistory_SI ? '0 : hist_q[j-1];
               end
            end
         end

         always_comb begin
            bound = '0;
            rot   = '0;
            for (int j = 0; j < NGRAM_SIZE-1; j++) begin
               rot = ClearHistory_SI ? '0 : hist_q[j];
               for (int r = 0; r <= j; r++)
                  rot = {rot[HV_DIMENSION-1], rot[0:HV_DIMENSION-2]};
               bound ^= rot;
            end
         end
      end else begin : g_nohist
         assign bound = '0;
      end
   endgenerate

`ifdef NGRAM_COUNT_EN
   always_ff @(posedge Clk_CI) begin
      if (!Reset_RBI)
         NgramCnt_DO <= '0;
      else if (xfer)
         NgramCnt_DO <= NgramCnt_DO + 16'd1;
   end
`endif

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Bench for temporal_ngram_encoder: directed test-plan cases plus random traffic vs a queue-based model.
// Runs an N=3 instance and an N=1 instance side by side on shared inputs.
module tb_temporal_ngram_encoder;

   localparam int D = 8;
   localparam int N = 3;
   typedef logic [0:D-1] hv_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, vin, rdy, clr;
   hv_t  m1, m2, m3;
   logic rdo, vo, rdo1, vo1;
   hv_t  hvo, hvo1;
`ifdef NGRAM_COUNT_EN
   logic [15:0] cnt, cnt1;
`endif

   int errors = 0;
   int checks = 0;

   // reference state
   logic        mvld, mvld1;
   hv_t         mout, mout1;
   hv_t         hq[$];
   logic [15:0] mcnt, mcnt1;
   hv_t         hold;

   temporal_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(N), .CNT_WIDTH(3)) dut (
      .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(vin), .ReadyOut_SO(rdo),
      .HypervectorIn_mod1_DI(m1), .HypervectorIn_mod2_DI(m2), .HypervectorIn_mod3_DI(m3),
      .ClearHistory_SI(clr), .ValidOut_SO(vo), .ReadyIn_SI(rdy), .HypervectorOut_DO(hvo)
`ifdef NGRAM_COUNT_EN
      , .NgramCnt_DO(cnt)
`endif
   );

   temporal_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(1), .CNT_WIDTH(1)) dut1 (
      .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(vin), .ReadyOut_SO(rdo1),
      .HypervectorIn_mod1_DI(m1), .HypervectorIn_mod2_DI(m2), .HypervectorIn_mod3_DI(m3),
      .ClearHistory_SI(clr), .ValidOut_SO(vo1), .ReadyIn_SI(rdy), .HypervectorOut_DO(hvo1)
`ifdef NGRAM_COUNT_EN
      , .NgramCnt_DO(cnt1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic hv_t fuse(input hv_t a, input hv_t b, input hv_t c);
      hv_t r;
      for (int k = 0; k < D; k++)
         r[k] = ((int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2);
      return r;
   endfunction

   // j rotations toward higher index
   function automatic hv_t rotj(input hv_t v, input int j);
      hv_t r;
      for (int k = 0; k < D; k++) r[(k + j) % D] = v[k];
      return r;
   endfunction

   function automatic hv_t rnd();
      return hv_t'($urandom_range(0, 255));
   endfunction

   task automatic step(input logic v, input hv_t a, input hv_t b, input hv_t c,
                       input logic r, input logic cl, input logic rs);
      logic acc, acc1, xf, xf1;
      hv_t  f, g;
      vin = v; m1 = a; m2 = b; m3 = c; rdy = r; clr = cl; rst_n = rs;
      #1;
      chk("ready",    32'(rdo),  32'(!mvld || r));
      chk("valid",    32'(vo),   32'(mvld));
      chk("hv",       32'(hvo),  32'(mout));
      chk("ready_n1", 32'(rdo1), 32'(!mvld1 || r));
      chk("valid_n1", 32'(vo1),  32'(mvld1));
      chk("hv_n1",    32'(hvo1), 32'(mout1));
`ifdef NGRAM_COUNT_EN
      chk("cnt",      32'(cnt),  32'(mcnt));
      chk("cnt_n1",   32'(cnt1), 32'(mcnt1));
`endif
      @(posedge clk);
      f    = fuse(a, b, c);
      acc  = v && (!mvld || r);
      acc1 = v && (!mvld1 || r);
      xf   = mvld && r;
      xf1  = mvld1 && r;
      if (!rs) begin
         mvld = 1'b0; mout = '0; mvld1 = 1'b0; mout1 = '0;
         mcnt = '0; mcnt1 = '0;
         hq.delete();
      end else begin
         if (xf)  mcnt++;
         if (xf1) mcnt1++;
         if (cl) hq.delete();
         if (acc) begin
            if (hq.size() >= N-1) begin
               g = f;
               for (int j = 1; j <= N-1; j++) g ^= rotj(hq[hq.size()-j], j);
               mout = g;
               mvld = 1'b1;
            end else if (xf) begin
               mvld = 1'b0;
            end
            hq.push_back(f);
            if (hq.size() > N-1) void'(hq.pop_front());
         end else if (xf) begin
            mvld = 1'b0;
         end
         if (acc1) begin
            mout1 = f;
            mvld1 = 1'b1;
         end else if (xf1) begin
            mvld1 = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic same(input logic v, input hv_t x, input logic r, input logic cl);
      step(v, x, x, x, r, cl, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; vin = 1'b0; rdy = 1'b1; clr = 1'b0;
      m1 = '0; m2 = '0; m3 = '0;
      mvld = 1'b0; mout = '0; mvld1 = 1'b0; mout1 = '0; mcnt = '0; mcnt1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // reset state, then fill window and first N-grams
      step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
      same(1'b1, 8'h80, 1'b1, 1'b0);
      chk("tp_fill1", 32'(vo), 32'd0);
      same(1'b1, 8'h01, 1'b1, 1'b0);
      chk("tp_fill2", 32'(vo), 32'd0);
      same(1'b1, 8'h10, 1'b1, 1'b0);
      chk("tp_b0_vld", 32'(vo), 32'd1);
      chk("tp_b0", 32'(hvo), 32'h0B0);
      same(1'b1, 8'h00, 1'b1, 1'b0);
      chk("tp_48", 32'(hvo), 32'h048);

      // majority on the N=1 instance
      step(1'b1, 8'hC0, 8'hA0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("tp_maj_n1", 32'(hvo1), 32'h080);

      // backpressure: output pending, downstream stalled
      hold = hvo;
      repeat (3) same(1'b1, 8'h3C, 1'b0, 1'b0);
      chk("bp_ready", 32'(rdo), 32'd0);
      chk("bp_hold", 32'(hvo), 32'(hold));
      same(1'b1, 8'h3C, 1'b1, 1'b0);
      chk("bp_new_vld", 32'(vo), 32'd1);

      // clear together with an accept
      same(1'b1, 8'h01, 1'b1, 1'b1);
      chk("clr_v1", 32'(vo), 32'd0);
      same(1'b1, 8'h04, 1'b1, 1'b0);
      chk("clr_v2", 32'(vo), 32'd0);
      same(1'b1, 8'h20, 1'b1, 1'b0);
      chk("clr_v3", 32'(vo), 32'd1);
      chk("clr_62", 32'(hvo), 32'h062);

      // reset while an output is pending
      same(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
      chk("rst_vld", 32'(vo), 32'd0);
      chk("rst_hv", 32'(hvo), 32'd0);
      same(1'b1, rnd(), 1'b1, 1'b0);
      same(1'b1, rnd(), 1'b1, 1'b0);
      chk("rst_fill", 32'(vo), 32'd0);
      same(1'b1, rnd(), 1'b1, 1'b0);
      chk("rst_out", 32'(vo), 32'd1);
      same(1'b0, 8'h00, 1'b1, 1'b0);

      // random traffic
      repeat (400)
         step($urandom_range(0, 9) < 6, rnd(), rnd(), rnd(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 99) != 0);
      same(1'b0, 8'h00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/temporal_ngram_encoder.md
Name: temporal_ngram_encoder

Overview:
- Downstream of the spatial encoder. Accepts the three per-modality spatial hypervectors with a valid/ready handshake.
- Fuses the three into one hypervector by bitwise majority, then binds it with the previous NGRAM_SIZE-1 fused vectors into an N-gram: permute by rotation, then XOR.
- Emits one N-gram hypervector per accepted sample once the window is full. Output goes to the associative-memory / classifier stage.

Parameters:
- HV_DIMENSION, 2000, hypervector width in bits; vectors indexed [0:HV_DIMENSION-1].
- NGRAM_SIZE, 3, samples per N-gram; legal range 1..8.
- CNT_WIDTH, 3, width of the fill counter; must satisfy 2**CNT_WIDTH > NGRAM_SIZE.

Ports:
- Clk_CI  in  1  clock; all state on rising edge.
- Reset_RBI  in  1  synchronous, active-low reset.
- ValidIn_SI  in  1  upstream valid; the three modality vectors below are stable while high.
- ReadyOut_SO  out  1  block can accept a sample this cycle.
- HypervectorIn_mod1_DI  in  HV_DIMENSION  modality 1 spatial hypervector.
- HypervectorIn_mod2_DI  in  HV_DIMENSION  modality 2 spatial hypervector.
- HypervectorIn_mod3_DI  in  HV_DIMENSION  modality 3 spatial hypervector.
- ClearHistory_SI  in  1  one-cycle pulse; restarts the N-gram window.
- ValidOut_SO  out  1  N-gram output valid.
- ReadyIn_SI  in  1  downstream ready.
- HypervectorOut_DO  out  HV_DIMENSION  registered N-gram hypervector.

Behaviour:
- Reset (Reset_RBI=0 at clock edge):
  - ValidOut_SO=0, HypervectorOut_DO=0.
  - History registers H1..H(N-1)=0, FillCntr=0.
  - Reset mid-operation discards any pending output and all history.
- Handshake:
  - Input accept when ValidIn_SI && ReadyOut_SO.
  - ReadyOut_SO = !ValidOut_SO || ReadyIn_SI (combinational). Full throughput when downstream is always ready; no combinational path from ValidIn_SI to ValidOut_SO.
  - Output transfer when ValidOut_SO && ReadyIn_SI. HypervectorOut_DO holds stable while ValidOut_SO=1 and ReadyIn_SI=0.
- Fusion: F[k] = maj(m1[k], m2[k], m3[k]), purely combinational on the inputs.
- Permutation rho: rotate by one position toward higher index: rho(V)[0]=V[D-1], rho(V)[k]=V[k-1]. rho^j is j rotations.
- N-gram: G = F XOR rho(H1) XOR rho^2(H2) XOR ... XOR rho^(N-1)(H(N-1)), where H1 is the most recent previously accepted F. For NGRAM_SIZE=1, G=F.
- On accept:
  - H1<=F, Hj<=H(j-1).
  - FillCntr <= min(FillCntr+1, NGRAM_SIZE).
  - If FillCntr+1 >= NGRAM_SIZE: HypervectorOut_DO<=G and ValidOut_SO<=1 next cycle (latency 1).
  - Otherwise the sample only fills history. ValidOut_SO is cleared if the pending output transferred this cycle, else it holds.
- No accept but output transfer: ValidOut_SO<=0.
- Control FSM:
  - FILL: FillCntr < NGRAM_SIZE.
  - STREAM: window full. FILL->STREAM on the accept that makes the count reach NGRAM_SIZE. STREAM->FILL only on ClearHistory_SI or reset.
- ClearHistory_SI:
  - H*<=0 and FillCntr<=0.
  - If a sample is accepted in the same cycle, clear wins for history, then that sample is written as H1 with FillCntr=1. No output is produced for it unless NGRAM_SIZE=1.
  - A pending output (ValidOut_SO=1) is unaffected by the clear and completes normally.
- FillCntr saturates at NGRAM_SIZE; it never wraps.

Optional Feature:
- Macro NGRAM_COUNT_EN.
- Defined: adds output port NgramCnt_DO, 16 bits, reset 0. It increments by 1 on each output transfer (ValidOut_SO && ReadyIn_SI) and wraps 0xFFFF->0x0000. ClearHistory_SI does not reset it.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan (D=8, N=3; vectors written index 0 leftmost as hex; m1=m2=m3 unless stated):
- Reset then accept F=0x80, 0x01, 0x10 with ReadyIn_SI=1 -> ValidOut_SO stays 0 for the first two samples. One cycle after the third accept: ValidOut_SO=1, HypervectorOut_DO=0xB0.
- Continue with F=0x00 -> HypervectorOut_DO=0x48.
- Majority: m1=0xC0, m2=0xA0, m3=0x00 with N=1 build -> HypervectorOut_DO=0x80.
- Backpressure: hold ReadyIn_SI=0 with an output pending -> ReadyOut_SO=0, output stable. Raise ReadyIn_SI together with ValidIn_SI -> transfer and new accept in the same cycle, with the new output the next cycle.
- ClearHistory_SI pulsed together with the accept of 0x01 after a full window -> no output for the next two accepts. The third accept after the clear yields an N-gram computed from post-clear samples only.
- Reset_RBI=0 while ValidOut_SO=1 -> next cycle ValidOut_SO=0, HypervectorOut_DO=0, and three new samples are needed before any output. With NGRAM_COUNT_EN, NgramCnt_DO=0 after reset and equals 2 after two transfers.
